// File: rtl/nibble_serial_adder_seq.sv
// Purpose : NIBBLES x 4-bit add/subtract done serially through one shared 4-bit adder, LS nibble first.
// Latency : START accepted at edge t -> BUSY for NIBBLES cycles -> DONE pulse and Q/flags valid at t+NIBBLES+1.
// Backpr. : no queueing; START is only sampled in IDLE or DONE, and is ignored while BUSY.
//
// Ports:
//   CLK, RESET      clock (rising edge) and synchronous active-high reset
//   START           request; sampled in IDLE or DONE, together with SUB, CIN, A, B
//   SUB, CIN        0 = add / 1 = subtract; carry-in (add) or borrow-in (subtract)
//   A, B            W-bit operands, W = 4*NIBBLES
//   BUSY, DONE      processing indicator; one-cycle completion pulse
//   Q, CO, V, Z     result, carry/borrow-out, signed overflow, zero flag (held until next completion)

// 4-bit full-adder macro shared by every nibble of the serial operation.
module fulladd4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] q,
    output logic       co
);
    assign {co, q} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 SUB,
    input  logic                 CIN,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [4*NIBBLES-1:0] Q,
    output logic                 CO,
    output logic                 V,
    output logic                 Z
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]     sa;       // operand A, shifted right one nibble per RUN cycle
    logic [W-1:0]     sb;       // operand B (pre-inverted for subtract), shifted likewise
    logic [W-5:0]     wr;       // completed nibbles; the final nibble is appended at completion
    logic             c;        // carry between nibbles
    logic             mode;     // latched SUB
    logic [IDX_W-1:0] idx;

    logic [3:0]       add_q;
    logic             add_co;
    logic [W-1:0]     wr_full;  // working register with the current adder nibble on top
    logic             accept;
    logic             last;

    fulladd4 u_fulladd4 (
        .a  (sa[3:0]),
        .b  (sb[3:0]),
        .ci (c),
        .q  (add_q),
        .co (add_co)
    );

    assign wr_full = {add_q, wr};
    assign accept  = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign last    = (state == ST_RUN) && (idx == LAST_IDX);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (START) state_nxt = ST_RUN;
            ST_RUN:  if (idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE: state_nxt = START ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state == ST_RUN);
        DONE = (state == ST_DONE);
    end

    // Datapath and result/flag registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sa   <= '0;
            sb   <= '0;
            wr   <= '0;
            c    <= 1'b0;
            mode <= 1'b0;
            idx  <= '0;
            Q    <= '0;
            CO   <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
        end else if (accept) begin
            sa   <= A;
            sb   <= SUB ? ~B : B;
            // Subtract is A + ~B + ~borrow_in.
            c    <= SUB ? ~CIN : CIN;
            mode <= SUB;
            idx  <= '0;
            wr   <= '0;
        end else if (state == ST_RUN) begin
            sa  <= {4'b0000, sa[W-1:4]};
            sb  <= {4'b0000, sb[W-1:4]};
            wr  <= wr_full[W-1:4];
            c   <= add_co;
            idx <= idx + IDX_W'(1);
            if (last) begin
                Q  <= wr_full;
                // In subtract mode the adder carry is the inverse of the borrow.
                CO <= mode ^ add_co;
                // Sign bits of this nibble are the operand sign bits (sb already inverted).
                V  <= (sa[3] == sb[3]) && (add_q[3] != sa[3]);
                Z  <= (wr_full == '0);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
module tb_nibble_serial_adder_seq;
    logic        CLK;
    logic        RESET;
    logic        START;
    logic        SUB;
    logic        CIN;
    logic [15:0] A;
    logic [15:0] B;
    logic        BUSY;
    logic        DONE;
    logic [15:0] Q;
    logic        CO;
    logic        V;
    logic        Z;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_seq #(.NIBBLES(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .SUB   (SUB),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Q     (Q),
        .CO    (CO),
        .V     (V),
        .Z     (Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Directed vectors: a, b, sub, cin -> q, co, v, z (hand computed)
    localparam int NV = 8;
    localparam logic [15:0] VA [NV] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF, 16'h0010, 16'h1234};
    localparam logic [15:0] VB [NV] = '{16'h4321, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001, 16'h0010, 16'h1234};
    localparam logic        VS [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic        VC [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] EQ [NV] = '{16'h5555, 16'h0000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    localparam logic        ECO[NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic        EV [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        EZ [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Stimulus only: called at a falling edge, returns at the falling edge after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
        A = a; B = b; SUB = sub; CIN = cin; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; SUB = 1'b0; CIN = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BUSY, DONE, CO, V, Z} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got BUSY/DONE/CO/V/Z=%b expected 00000", {BUSY, DONE, CO, V, Z});
        end
        checks++;
        if (Q !== 16'h0000) begin
            errors++;
            $display("FAIL reset_q: got %h expected 0000", Q);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got BUSY=%b DONE=%b expected 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_arith;
        for (int i = 0; i < NV; i++) begin
            start_op(VA[i], VB[i], VS[i], VC[i]);
            for (int k = 1; k <= 4; k++) begin
                checks++;
                if (BUSY !== 1'b1 || DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL arith%0d_busy_c%0d: got BUSY=%b DONE=%b expected 1 0", i, k, BUSY, DONE);
                end
                @(negedge CLK);
            end
            checks++;
            if (DONE !== 1'b1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL arith%0d_done: got DONE=%b BUSY=%b expected 1 0", i, DONE, BUSY);
            end
            checks++;
            if (Q !== EQ[i] || CO !== ECO[i] || V !== EV[i] || Z !== EZ[i]) begin
                errors++;
                $display("FAIL arith%0d_result: got Q=%h CO=%b V=%b Z=%b expected Q=%h CO=%b V=%b Z=%b",
                         i, Q, CO, V, Z, EQ[i], ECO[i], EV[i], EZ[i]);
            end
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || Q !== EQ[i]) begin
                errors++;
                $display("FAIL arith%0d_hold: got DONE=%b BUSY=%b Q=%h expected 0 0 %h", i, DONE, BUSY, Q, EQ[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        @(negedge CLK);
        // Second request mid-run with different operands must be dropped.
        A = 16'h1111; B = 16'h1111; SUB = 1'b1; CIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: got BUSY=%b expected 1", BUSY);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || Q !== 16'h8000 || V !== 1'b1 || CO !== 1'b0 || Z !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got DONE=%b Q=%h CO=%b V=%b Z=%b expected 1 8000 0 1 0", DONE, Q, CO, V, Z);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_queue: got BUSY=%b DONE=%b expected 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_back_to_back;
        A = 16'h1111; B = 16'h2222; SUB = 1'b0; CIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        // Second operand set, START stays high throughout the first run.
        A = 16'h4000; B = 16'h4000;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (BUSY !== 1'b1 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first_busy_c%0d: got BUSY=%b DONE=%b expected 1 0", k, BUSY, DONE);
            end
            @(negedge CLK);
        end
        checks++;
        if (DONE !== 1'b1 || Q !== 16'h3333 || CO !== 1'b0 || V !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done: got DONE=%b Q=%h CO=%b V=%b expected 1 3333 0 0", DONE, Q, CO, V);
        end
        @(negedge CLK);
        START = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            checks++;
            if (BUSY !== 1'b1 || DONE !== 1'b0 || Q !== 16'h3333) begin
                errors++;
                $display("FAIL b2b_second_busy_c%0d: got BUSY=%b DONE=%b Q=%h expected 1 0 3333", k, BUSY, DONE, Q);
            end
            @(negedge CLK);
        end
        checks++;
        if (DONE !== 1'b1 || Q !== 16'h8000 || CO !== 1'b0 || V !== 1'b1 || Z !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_done: got DONE=%b Q=%h CO=%b V=%b Z=%b expected 1 8000 0 1 0", DONE, Q, CO, V, Z);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got BUSY=%b DONE=%b expected 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_reset_mid;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if ({BUSY, DONE, CO, V, Z} !== 5'b00000 || Q !== 16'h0000) begin
            errors++;
            $display("FAIL abort_outputs: got BUSY/DONE/CO/V/Z=%b Q=%h expected 00000 0000", {BUSY, DONE, CO, V, Z}, Q);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got DONE=%b BUSY=%b expected 0 0", DONE, BUSY);
        end
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (BUSY !== 1'b1 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL after_abort_busy_c%0d: got BUSY=%b DONE=%b expected 1 0", k, BUSY, DONE);
            end
            @(negedge CLK);
        end
        checks++;
        if (DONE !== 1'b1 || Q !== 16'h1000 || CO !== 1'b0 || V !== 1'b0 || Z !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_result: got DONE=%b Q=%h CO=%b V=%b Z=%b expected 1 1000 0 0 0", DONE, Q, CO, V, Z);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
